daq_read_arbiter: RTL

- Shares the single read port of the DAQ event buffer (15-bit word address, 64-bit read data, fixed read latency) between two requesters:
  - the DMA engine, which issues bursts;
  - the AXI register-read path, which issues single-word peeks.
- Runs in the dma_clk domain, between the requesters and the buffer's port B.
- Tags each returned word with its owner and marks the last word of each DMA burst.

---
 rtl/daq_read_arbiter_pkg.sv | 15 +
 rtl/daq_read_arbiter_if.sv | 37 +++
 rtl/daq_read_arbiter_return_pipe.sv | 45 ++++
 rtl/daq_read_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/daq_read_arbiter_pkg.sv
// rtl/daq_read_arbiter_pkg.sv - shared DAQ buffer constants, owner encoding and arbiter states
package daq_pkg;

    localparam int DAQ_BUF_ADDR_W = 15;

    localparam logic OWN_DMA = 1'b0;
    localparam logic OWN_AXI = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DMA_BURST = 2'd1,
        AXI_RD    = 2'd2
    } arb_state_t;

endpackage

// File: rtl/daq_read_arbiter_if.sv
// rtl/daq_read_arbiter_if.sv - requester, buffer port B and return signals of the DAQ read arbiter
interface daq_read_arbiter_if
    import daq_pkg::*;
#(
    parameter int ADDR_W = DAQ_BUF_ADDR_W,
    parameter int DATA_W = 64
);
    logic              dma_req;
    logic [ADDR_W-1:0] dma_addr;
    logic [4:0]        dma_len;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic              dma_rlast;
    logic              axi_req;
    logic [ADDR_W-1:0] axi_addr;
    logic              axi_gnt;
    logic              axi_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    // master: requesters plus the buffer; slave: the arbiter
    modport master (
        output dma_req, dma_addr, dma_len, axi_req, axi_addr, mem_dout,
        input  dma_gnt, dma_rvalid, dma_rlast, axi_gnt, axi_rvalid,
               mem_addr, mem_en, rdata, busy
    );

    modport slave (
        input  dma_req, dma_addr, dma_len, axi_req, axi_addr, mem_dout,
        output dma_gnt, dma_rvalid, dma_rlast, axi_gnt, axi_rvalid,
               mem_addr, mem_en, rdata, busy
    );

endinterface

// File: rtl/daq_read_arbiter_return_pipe.sv
// rtl/daq_read_arbiter_return_pipe.sv - RD_LAT+1 deep {valid, owner, last} tag pipe with aligned data register
module daq_read_return_pipe #(
    parameter int RD_LAT = 2,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_owner,
    input  logic              in_last,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] rdata,
    output logic              out_valid,
    output logic              out_owner,
    output logic              out_last,
    output logic              busy
);

    logic [RD_LAT:0] vld;
    logic [RD_LAT:0] own;
    logic [RD_LAT:0] lst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld   <= '0;
            own   <= '0;
            lst   <= '0;
            rdata <= '0;
        end else begin
            vld <= {vld[RD_LAT-1:0], in_valid};
            own <= {own[RD_LAT-1:0], in_owner};
            lst <= {lst[RD_LAT-1:0], in_last};
            // buffer data for a tag is on mem_dout one cycle before the tag reaches the output
            if (vld[RD_LAT-1]) begin
                rdata <= mem_dout;
            end
        end
    end

    assign out_valid = vld[RD_LAT];
    assign out_owner = own[RD_LAT];
    assign out_last  = lst[RD_LAT];
    assign busy      = |vld;

endmodule

// File: rtl/daq_read_arbiter.sv
// rtl/daq_read_arbiter.sv - DMA burst / AXI peek arbiter for DAQ buffer port B; stats under DAQ_READ_ARB_STATS_EN
module daq_read_arbiter
    import daq_pkg::*;
#(
    parameter int ADDR_W       = DAQ_BUF_ADDR_W,
    parameter int DATA_W       = 64,
    parameter int RD_LAT       = 2,
    parameter int MAX_BURST    = 16,
    parameter int AXI_MAX_WAIT = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_dma_priority,
    daq_read_arbiter_if.slave  bus
`ifdef DAQ_READ_ARB_STATS_EN
    ,
    output logic [31:0]        stat_dma_words,
    output logic [31:0]        stat_axi_words,
    output logic [15:0]        stat_axi_forced
`endif
);

    localparam int                WAIT_W   = $clog2(AXI_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(AXI_MAX_WAIT);
    localparam logic [4:0]        LEN_MAX  = 5'(MAX_BURST - 1);

    arb_state_t        state, state_nxt;
    logic [ADDR_W-1:0] start_q, axi_addr_q;
    logic [4:0]        len_q, beat;
    logic              last_winner;
    logic [WAIT_W-1:0] wait_cnt;
    logic              burst_last, can_eval, pick_dma, pick_axi, forced;
    logic              out_valid, out_owner, out_last, pipe_busy;

    always_comb begin
        burst_last = (state == DMA_BURST) && (beat == len_q);
        can_eval   = (state == IDLE) || burst_last;
        pick_dma   = 1'b0;
        pick_axi   = 1'b0;
        forced     = 1'b0;
        // grants are masked during reset so every output reads 0 while it is held
        if (can_eval && !reset) begin
            if (bus.dma_req && bus.axi_req) begin
                if (wait_cnt >= WAIT_MAX) begin
                    pick_axi = 1'b1;
                    forced   = 1'b1;
                end else if (cfg_dma_priority) begin
                    pick_dma = 1'b1;
                end else if (last_winner == OWN_DMA) begin
                    pick_axi = 1'b1;
                end else begin
                    pick_dma = 1'b1;
                end
            end else if (bus.dma_req) begin
                pick_dma = 1'b1;
            end else if (bus.axi_req) begin
                pick_axi = 1'b1;
            end
        end

        state_nxt = state;
        if (pick_dma) begin
            state_nxt = DMA_BURST;
        end else if (pick_axi) begin
            state_nxt = AXI_RD;
        end else if ((state == AXI_RD) || burst_last) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            start_q     <= '0;
            axi_addr_q  <= '0;
            len_q       <= '0;
            beat        <= '0;
            last_winner <= OWN_AXI;
            wait_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (pick_dma) begin
                start_q     <= bus.dma_addr;
                len_q       <= (bus.dma_len > LEN_MAX) ? LEN_MAX : bus.dma_len;
                beat        <= '0;
                last_winner <= OWN_DMA;
            end else if (state == DMA_BURST) begin
                beat <= beat + 5'd1;
            end
            if (pick_axi) begin
                axi_addr_q  <= bus.axi_addr;
                last_winner <= OWN_AXI;
                wait_cnt    <= '0;
            end else if (bus.axi_req && (wait_cnt < WAIT_MAX)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign bus.dma_gnt  = pick_dma;
    assign bus.axi_gnt  = pick_axi;
    assign bus.mem_en   = (state != IDLE);
    assign bus.mem_addr = (state == DMA_BURST) ? start_q + ADDR_W'(beat) :
                          (state == AXI_RD)    ? axi_addr_q : '0;

    daq_read_return_pipe #(
        .RD_LAT (RD_LAT),
        .DATA_W (DATA_W)
    ) u_return_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (state != IDLE),
        .in_owner  ((state == AXI_RD) ? OWN_AXI : OWN_DMA),
        .in_last   (burst_last),
        .mem_dout  (bus.mem_dout),
        .rdata     (bus.rdata),
        .out_valid (out_valid),
        .out_owner (out_owner),
        .out_last  (out_last),
        .busy      (pipe_busy)
    );

    assign bus.dma_rvalid = out_valid && (out_owner == OWN_DMA);
    assign bus.dma_rlast  = out_valid && (out_owner == OWN_DMA) && out_last;
    assign bus.axi_rvalid = out_valid && (out_owner == OWN_AXI);
    assign bus.busy       = (state != IDLE) || pipe_busy;

`ifdef DAQ_READ_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_dma_words  <= '0;
            stat_axi_words  <= '0;
            stat_axi_forced <= '0;
        end else begin
            if (state == DMA_BURST) stat_dma_words <= stat_dma_words + 32'd1;
            if (state == AXI_RD)    stat_axi_words <= stat_axi_words + 32'd1;
            if (forced)             stat_axi_forced <= stat_axi_forced + 16'd1;
        end
    end
`endif

endmodule
